// File: rtl/bit_sync_pkg.sv
// Shared definitions for the chip spreader and the correlator side:
// FSM state encoding, chip value constants and the default spreading code.
package bit_sync_pkg;

    // Spreader FSM states, also exposed on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } state_e;

    // Chip values, same encoding as the correlator ref input.
    localparam logic signed [7:0] CHIP_POS  = 8'sd1;
    localparam logic signed [7:0] CHIP_NEG  = -8'sd1;
    localparam logic signed [7:0] CHIP_ZERO = 8'sd0;

    // Default 8-chip spreading code; MSB is transmitted first.
    localparam logic [7:0] DEFAULT_CODE = 8'b1011_0010;

endpackage

// File: rtl/chip_tick_gen.sv
// Chip-rate divider: counts 0..CLK_PER_CHIP-1 while enabled and flags the
// last clock of each chip. Held at zero when disabled so a new frame always
// starts on a fresh chip boundary.
module chip_tick_gen #(
    parameter int CLK_PER_CHIP = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int DW = (CLK_PER_CHIP > 1) ? $clog2(CLK_PER_CHIP) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_PER_CHIP - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    // Next divider value: clear when disabled or at the last clock of a chip.
    always_comb begin
        div_d = div_q;
        if (!en) begin
            div_d = '0;
        end else if (div_q == LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Divider register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = en && (div_q == LAST);

endmodule

// File: rtl/chip_spreader.sv
// Direct-sequence spreader. Each accepted bit is sent as CODE_LEN chips of
// CLK_PER_CHIP clocks each; a frame opens with PREAMBLE_SYMS symbols of bit 1
// and continues as long as the source supplies a new bit on the last clock of
// every data symbol. A missed handshake ends the frame with an underrun pulse.
//
// Handshake: a transfer happens on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends on registered state only; in and
// in_valid are don't-care on cycles without a transfer.
module chip_spreader
    import bit_sync_pkg::*;
#(
    parameter int                CODE_LEN      = 8,
    parameter logic [CODE_LEN-1:0] CODE        = DEFAULT_CODE,
    parameter int                CLK_PER_CHIP  = 4,
    parameter int                PREAMBLE_SYMS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic signed [7:0] chip,
    output logic              chip_valid,
    output logic              frame_start,
    output logic              underrun,
    output logic [1:0]        state_o
);

    localparam int CW = $clog2(CODE_LEN);
    localparam logic [CW-1:0] LAST_CHIP = CW'(CODE_LEN - 1);
    localparam logic [7:0]    LAST_SYM  = 8'(PREAMBLE_SYMS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] chip_cnt_q, chip_cnt_d;
    logic [7:0]    sym_cnt_q, sym_cnt_d;
    logic          cur_bit_q, cur_bit_d;
    logic          frame_start_q, frame_start_d;
    logic          underrun_q, underrun_d;

    logic          tick;
    logic          sym_end;
    logic          xfer;
    logic [CW-1:0] code_idx;
    logic          code_bit;
    logic          sym_bit;
    logic          chip_bit;

    chip_tick_gen #(
        .CLK_PER_CHIP(CLK_PER_CHIP)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (state_q != ST_IDLE),
        .tick(tick)
    );

    assign sym_end  = tick && (chip_cnt_q == LAST_CHIP);
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DATA) && sym_end);
    assign xfer     = in_valid && in_ready;

    // Next-state logic for the frame FSM and its counters.
    always_comb begin
        state_d       = state_q;
        chip_cnt_d    = chip_cnt_q;
        sym_cnt_d     = sym_cnt_q;
        cur_bit_d     = cur_bit_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (tick) begin
            chip_cnt_d = sym_end ? '0 : chip_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                chip_cnt_d = '0;
                sym_cnt_d  = '0;
                if (xfer) begin
                    cur_bit_d     = in;
                    state_d       = ST_PREAMBLE;
                    frame_start_d = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                if (sym_end) begin
                    if (sym_cnt_q == LAST_SYM) begin
                        sym_cnt_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 8'd1;
                    end
                end
            end
            ST_DATA: begin
                if (sym_end) begin
                    if (xfer) begin
                        cur_bit_d = in;
                    end else begin
                        state_d    = ST_IDLE;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any frame without an underrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            chip_cnt_q    <= '0;
            sym_cnt_q     <= '0;
            cur_bit_q     <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            chip_cnt_q    <= chip_cnt_d;
            sym_cnt_q     <= sym_cnt_d;
            cur_bit_q     <= cur_bit_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign code_idx = LAST_CHIP - chip_cnt_q;
    assign code_bit = CODE[code_idx];
    assign sym_bit  = (state_q == ST_DATA) ? cur_bit_q : 1'b1;
    assign chip_bit = ~(code_bit ^ sym_bit);

    // Chip output decoded from registered state only.
    always_comb begin
        chip       = CHIP_ZERO;
        chip_valid = 1'b0;
        if (state_q != ST_IDLE) begin
            chip       = chip_bit ? CHIP_POS : CHIP_NEG;
            chip_valid = 1'b1;
        end
    end

    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_chip_spreader.sv
// Bench for chip_spreader: a default-parameter instance and a fast instance
// (one clock per chip, one preamble symbol), checked every cycle against a
// frame-level reference model.
module tb_chip_spreader;
  import bit_sync_pkg::*;

  localparam int CL = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic in_d = 1'b0;
  logic in_v = 1'b0;
  logic sel = 1'b0;

  logic              ready0, ready1, cv0, cv1, fs0, fs1, ur0, ur1;
  logic signed [7:0] chip0, chip1;
  logic [1:0]        st0, st1;

  chip_spreader u0 (
    .clk(clk), .rst(rst), .in(in_d), .in_valid(in_v & ~sel),
    .in_ready(ready0), .chip(chip0), .chip_valid(cv0),
    .frame_start(fs0), .underrun(ur0), .state_o(st0)
  );

  chip_spreader #(.CLK_PER_CHIP(1), .PREAMBLE_SYMS(1)) u1 (
    .clk(clk), .rst(rst), .in(in_d), .in_valid(in_v & sel),
    .in_ready(ready1), .chip(chip1), .chip_valid(cv1),
    .frame_start(fs1), .underrun(ur1), .state_o(st1)
  );

  logic signed [7:0] o_chip;
  logic              o_ready, o_cv, o_fs, o_ur;
  logic [1:0]        o_st;
  assign o_chip  = sel ? chip1 : chip0;
  assign o_ready = sel ? ready1 : ready0;
  assign o_cv    = sel ? cv1 : cv0;
  assign o_fs    = sel ? fs1 : fs0;
  assign o_ur    = sel ? ur1 : ur0;
  assign o_st    = sel ? st1 : st0;

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] code_v = 8'b1011_0010;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: chip index ci of a symbol carrying bit b is +1 when the code
  // bit equals b, else -1.
  function automatic int ref_chip(int ci, logic b);
    return (code_v[CL-1-ci] == b) ? 1 : -1;
  endfunction

  function automatic int model_chip(int t, int cpc, int pre, logic [7:0] bits);
    int sym_cyc = CL * cpc;
    int k = t / sym_cyc;
    int ci = (t % sym_cyc) / cpc;
    logic b = (k < pre) ? 1'b1 : bits[k-pre];
    return ref_chip(ci, b);
  endfunction

  // ---------------- driver / checker ----------------
  // t = 0 is the first preamble cycle; t = total is the first idle cycle.
  task automatic run_frame(input logic s, input int cpc, input int pre,
                           input int nbits, input logic [7:0] bits);
    int sym_cyc = CL * cpc;
    int pre_cyc = pre * sym_cyc;
    int total = pre_cyc + nbits * sym_cyc;
    int corr = 0;
    int d;
    logic exp_rdy;
    logic signed [7:0] e;
    sel = s;
    exp_q.delete();
    for (int t = 0; t < total; t++) exp_q.push_back(8'(model_chip(t, cpc, pre, bits)));
    exp_q.push_back(8'd0);
    @(negedge clk);
    check("idle_ready", o_ready, 1);
    in_d = bits[0];
    in_v = 1'b1;
    for (int t = 0; t <= total; t++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      d = (t >= pre_cyc) ? (t - pre_cyc) / sym_cyc : -1;
      exp_rdy = (t == total) || (t >= pre_cyc && (t % sym_cyc) == sym_cyc - 1);
      check($sformatf("chip t=%0d", t), o_chip, e);
      check($sformatf("chip_valid t=%0d", t), o_cv, t < total);
      check($sformatf("frame_start t=%0d", t), o_fs, t == 0);
      check($sformatf("underrun t=%0d", t), o_ur, t == total);
      check($sformatf("in_ready t=%0d", t), o_ready, exp_rdy);
      // Loopback correlation against the code, one sample per chip.
      if (t < total && t >= pre_cyc) begin
        if (((t - pre_cyc) % cpc) == 0)
          corr += int'(o_chip) * ref_chip(((t - pre_cyc) % sym_cyc) / cpc, 1'b1);
        if (((t - pre_cyc) % sym_cyc) == sym_cyc - 1) begin
          check($sformatf("corr sym=%0d", d), corr, bits[d] ? CL : -CL);
          corr = 0;
        end
      end
      if (exp_rdy) begin
        in_v = (t < total) && (d + 1 < nbits);
        in_d = in_v ? bits[d+1] : 1'b0;
      end else begin
        in_v = 1'($urandom_range(0, 1));
        in_d = 1'($urandom_range(0, 1));
      end
    end
    in_v = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    in_v = 1'b1;
    in_d = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_chip", chip0, 0);
    check("rst_chip_valid", cv0, 0);
    check("rst_frame_start", fs0, 0);
    check("rst_underrun", ur0, 0);
    check("rst_in_ready", ready0, 1);
    check("rst_state", st0, ST_IDLE);
    in_v = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_state", st0, ST_IDLE);

    // Single 0 bit with default parameters.
    run_frame(1'b0, 4, 4, 1, 8'b0);
    // Bits 1,0,1 back to back: in_ready at 159 and 191.
    run_frame(1'b0, 4, 4, 3, 8'b0000_0101);
    // Fast instance: every chip one clock, back-to-back handshakes.
    run_frame(1'b1, 1, 1, 4, 8'b0000_1001);
    for (int i = 0; i < 3; i++) begin
      run_frame(1'b0, 4, 4, $urandom_range(1, 5), 8'($urandom));
      run_frame(1'b1, 1, 1, $urandom_range(1, 8), 8'($urandom));
    end

    // Reset in the middle of data chip 5.
    sel = 1'b0;
    @(negedge clk);
    in_d = 1'b1;
    in_v = 1'b1;
    @(negedge clk);
    in_v = 1'b0;
    repeat (4 * CL * 4 + 5 * 4 + 1) @(negedge clk);
    check("pre_abort_state", st0, ST_DATA);
    check("pre_abort_valid", cv0, 1);
    rst = 1'b1;
    #1;
    check("abort_chip", chip0, 0);
    check("abort_chip_valid", cv0, 0);
    check("abort_state", st0, ST_IDLE);
    check("abort_in_ready", ready0, 1);
    check("abort_underrun", ur0, 0);
    in_v = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_xfer_discard_fs", fs0, 0);
    check("rst_xfer_discard_state", st0, ST_IDLE);
    in_v = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_underrun", ur0, 0);
      check("post_abort_valid", cv0, 0);
    end

    // First frame after reset behaves normally.
    run_frame(1'b0, 4, 4, 2, 8'b0000_0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
